// File: rtl/sobel_pkg.sv
// sobel_pkg: shared definitions for the Sobel stream filter.
//   - MAG_SUM / MAG_MAX : encodings of the MAG_MODE parameter
//   - KGX / KGY         : 3x3 Sobel kernels, indexed [row top..bottom][col left..right]
//   - grad_w()          : signed width that holds Gx/Gy without overflow
package sobel_pkg;

  localparam int MAG_SUM = 0;  // (|Gx|+|Gy|)>>1
  localparam int MAG_MAX = 1;  // max(|Gx|,|Gy|)

  localparam int KGX [0:2][0:2] = '{'{-1, 0, 1},
                                    '{-2, 0, 2},
                                    '{-1, 0, 1}};
  localparam int KGY [0:2][0:2] = '{'{-1, -2, -1},
                                    '{ 0,  0,  0},
                                    '{ 1,  2,  1}};

  // Kernel weights sum to 4 per side, so |G| <= 4*(2^PIX_W-1): PIX_W+2
  // magnitude bits plus a sign bit.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one image row of storage.
//   clk_i     : clock
//   en_i      : perform the read/write for this column (one accepted pixel)
//   addr_i    : column address
//   wr_data_i : value stored at addr_i on the rising edge when en_i=1
//   rd_data_o : current (pre-write) content at addr_i, combinational
// Contents are deliberately not reset; the filter refills rows before use.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wr_data_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (en_i) mem_q[addr_i] <= wr_data_i;
  end

endmodule

// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: streaming 3x3 Sobel edge magnitude, interior pixels only.
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   thr_en_i, thr_i        : optional binarisation against thr_i
//   in_valid_i/in_ready_o  : raster-order grey pixel input (in_pix_i, in_sop_i)
//   out_valid_o/out_ready_i: edge output (out_pix_o, out_sop_o, out_eop_o)
//   frame_err_o            : sticky, set when in_sop_i arrives mid-frame
// The output for centre (x-1,y-1) is registered on the edge that accepts
// input (x,y), giving one cycle of latency through a one-deep output register.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int MAG_MODE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             thr_en_i,
  input  logic [PIX_W-1:0] thr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [PIX_W-1:0] in_pix_i,
  input  logic             in_sop_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PIX_W-1:0] out_pix_o,
  output logic             out_sop_o,
  output logic             out_eop_o,
  output logic             frame_err_o
);

  localparam int GW = grad_w(PIX_W);
  localparam int AW = PIX_W + 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic          out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic          frame_err_q, frame_err_d;

  logic accept, restart, emit;

  // Window columns 0 (oldest) and 1; column 2 is the incoming column.
  logic [2:0][1:0][PIX_W-1:0] win_q, win_d;
  logic [2:0][2:0][PIX_W-1:0] win;
  logic [2:0][PIX_W-1:0]      col_new;
  logic [PIX_W-1:0]           lb0_rd, lb1_rd;

  logic signed [GW-1:0] gx, gy;
  logic [AW-1:0]        ax, ay, mag_raw;
  logic [AW:0]          mag_sum;
  logic [PIX_W-1:0]     mag_sat, pix_res;
  int                   gx_acc, gy_acc;

  assign in_ready_o = out_ready_i | ~out_valid_q;
  assign accept     = in_valid_i & in_ready_o;
  // A start-of-frame anywhere but (0,0) re-anchors the counters at this pixel.
  assign restart    = accept & in_sop_i & ((col_q != '0) | (row_q != '0));
  assign cur_col    = restart ? '0 : col_q;
  assign cur_row    = restart ? '0 : row_q;
  assign emit       = accept & (cur_col >= CW'(2)) & (cur_row >= RW'(2));

  // lb0 holds row y-1, lb1 holds row y-2; rows shift down as columns pass.
  sobel_line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb0 (
    .clk_i    (clk_i),
    .en_i     (accept),
    .addr_i   (cur_col),
    .wr_data_i(in_pix_i),
    .rd_data_o(lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
    .clk_i    (clk_i),
    .en_i     (accept),
    .addr_i   (cur_col),
    .wr_data_i(lb0_rd),
    .rd_data_o(lb1_rd)
  );

  assign col_new[0] = lb1_rd;
  assign col_new[1] = lb0_rd;
  assign col_new[2] = in_pix_i;

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win[r][0] = win_q[r][0];
      win[r][1] = win_q[r][1];
      win[r][2] = col_new[r];
      if (accept) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = col_new[r];
      end
    end
  end

  always_comb begin
    gx_acc = 0;
    gy_acc = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        gx_acc = gx_acc + KGX[r][c] * int'(win[r][c]);
        gy_acc = gy_acc + KGY[r][c] * int'(win[r][c]);
      end
    end
    gx      = GW'(gx_acc);
    gy      = GW'(gy_acc);
    ax      = gx[GW-1] ? AW'(-gx) : AW'(gx);
    ay      = gy[GW-1] ? AW'(-gy) : AW'(gy);
    mag_sum = {1'b0, ax} + {1'b0, ay};
    if (MAG_MODE == MAG_MAX) mag_raw = (ax > ay) ? ax : ay;
    else                     mag_raw = mag_sum[AW:1];
    mag_sat = (mag_raw > AW'(PIX_MAX)) ? PIX_MAX : mag_raw[PIX_W-1:0];
    pix_res = thr_en_i ? ((mag_sat >= thr_i) ? PIX_MAX : '0) : mag_sat;
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q & ~out_ready_i;
    out_pix_d   = out_pix_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    frame_err_d = frame_err_q | restart;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_pix_d   = pix_res;
      out_sop_d   = (cur_col == CW'(2)) & (cur_row == RW'(2));
      out_eop_d   = (cur_col == COL_LAST) & (cur_row == ROW_LAST);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Window contents are only consumed once refilled, so no reset is needed.
  always_ff @(posedge clk_i) begin
    win_q <= win_d;
  end

  assign out_valid_o = out_valid_q;
  assign out_pix_o   = out_pix_q;
  assign out_sop_o   = out_sop_q;
  assign out_eop_o   = out_eop_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, frame width in pixels (>=3).
REQ-003 SHALL have parameter IMG_H, default 480, frame height in pixels (>=3).
REQ-004 SHALL have parameter MAG_MODE, default 0, magnitude mode: 0 = (|Gx|+|Gy|)>>1, 1 = max(|Gx|,|Gy|).
REQ-005 SHALL have ports:
- clk_i  in  1  clock; one clock domain, all logic on rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- thr_en_i  in  1  1 = binarise output.
- thr_i  in  PIX_W  threshold, sampled with each input pixel.
- in_valid_i  in  1  input pixel valid.
- in_ready_o  out  1  input pixel accepted when valid and ready.
- in_pix_i  in  PIX_W  grey pixel, raster order.
- in_sop_i  in  1  first pixel of frame.
- out_valid_o  out  1  output pixel valid.
- out_ready_i  in  1  sink ready.
- out_pix_o  out  PIX_W  edge magnitude.
- out_sop_o  out  1  first interior pixel of frame.
- out_eop_o  out  1  last interior pixel of frame.
- frame_err_o  out  1  sticky: in_sop_i seen mid-frame.

Function
REQ-006 SHALL compute 3x3 Sobel: Gx = [-1 0 1; -2 0 2; -1 0 1], Gy = [-1 -2 -1; 0 0 0; 1 2 1], window rows top to bottom.
REQ-007 SHALL emit only interior pixels: (IMG_W-2)*(IMG_H-2) outputs per frame, raster order; no border padding.
REQ-008 SHALL buffer two previous rows in line buffers of depth IMG_W, plus a 3x3 window shift register.
REQ-009 SHALL track input column 0..IMG_W-1 and row 0..IMG_H-1; column wraps to 0 and row increments at IMG_W-1; both wrap to 0 after the last pixel of a frame.
REQ-010 SHALL produce the output for window centre (x-1,y-1) on out_pix_o in the cycle after accepting input pixel (x,y) with x>=2, y>=2 (latency 1 cycle).
REQ-011 SHALL hold Gx, Gy as signed PIX_W+3 bits; |Gx|,|Gy| unsigned PIX_W+2 bits; no intermediate overflow.
REQ-012 SHALL saturate magnitude to 2^PIX_W-1.
REQ-013 SHALL, when thr_en_i=1, output 2^PIX_W-1 if saturated magnitude >= thr_i, else 0.
REQ-014 SHALL drive in_ready_o = out_ready_i OR NOT out_valid_o (one-deep output register, no bubbles under continuous flow).
REQ-015 SHALL keep out_pix_o, out_sop_o and out_eop_o stable while out_valid_o=1 and out_ready_i=0.
REQ-016 SHALL not advance counters, line buffers or window when no input is accepted.
REQ-017 SHALL assert out_sop_o with the output for centre (1,1) and out_eop_o with the output for centre (IMG_W-2,IMG_H-2).
REQ-018 SHALL, on in_sop_i accepted with counters not at (0,0), set frame_err_o and restart counters so that pixel becomes (0,0); in_sop_i at (0,0) is accepted normally.
REQ-019 SHALL treat in_sop_i as ignored when in_valid_i=0.

Reset
REQ-020 SHALL on rst_i low clear out_valid_o, out_pix_o, out_sop_o, out_eop_o, frame_err_o and both counters to 0 asynchronously; in_ready_o then evaluates to 1.
REQ-021 SHALL not clear line-buffer contents on reset; stale data never reaches the output because rows 0-1 of the new frame refill them first.
REQ-022 SHALL, on reset mid-frame, discard the partial frame; the next accepted pixel is (0,0).

Structure
REQ-023 SHALL place kernel coefficients, MAG_MODE encodings and the Gx/Gy width function in package sobel_pkg.
REQ-024 SHALL implement each row store as sub-module sobel_line_buffer (depth IMG_W, width PIX_W, one read/one write per accepted pixel), instantiated twice.

Verification
REQ-025 SHALL cover: 4x4 frame, all pixels 100 -> 4 outputs, all 0; sop on first, eop on fourth.
REQ-026 SHALL cover: 4x4 frame, columns 0-1 = 0, columns 2-3 = 255, MAG_MODE=0 -> each output 255 (Gx 1020, (1020+0)>>1 = 510, saturated).
REQ-027 SHALL cover: 5x5 diagonal ramp pix=x+y, MAG_MODE=1 -> Gx=Gy=8, every output 8 (9 outputs); MAG_MODE=0 -> every output 8.
REQ-028 SHALL cover: REQ-027 stimulus with thr_en_i=1, thr_i=8 -> all 255; thr_i=9 -> all 0.
REQ-029 SHALL cover: random out_ready_i (50%) and in_valid_i gaps on a 16x8 frame -> output sequence identical to the no-stall reference, 84 outputs, data stable while stalled.
REQ-030 SHALL cover: rst_i low after 10 pixels of a 4x4 frame, then full frame -> exactly 4 outputs, frame_err_o=0; in_sop_i at pixel 5 of a frame -> frame_err_o=1, remains set until reset.
